// File: rtl/decode_stage.sv
// decode_stage: registered MIPS decode with valid/ready handshake, load-use bubble and stall counter
module decode_stage #(
    parameter bit EXT_EN = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm16,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             jump,
    output logic             branch,
    output logic             branch_ne,
    output logic             sign_ext,
    output logic             alu_src,
    output logic [3:0]       alu_ctr,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b1001;
    localparam logic [3:0] ALU_OR  = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [12:0] ILL    = {8'b0, 1'b1, 4'b0};
    logic [5:0]       op, fn;
    logic [12:0]      ctl_d, ctl_q;
    logic [4:0]       rs_q, rt_q, rd_q;
    logic [15:0]      imm_q;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reads_rt, hazard, accept, stall;
    assign op = in_instr[31:26];
    assign fn = in_instr[5:0];
    // ctl = {reg_write, mem_read, mem_write, jump, branch, branch_ne, sign_ext, alu_src, illegal, alu_ctr}
    always_comb begin
        ctl_d = ILL;
        case (op)
            6'b000000: case (fn)
                6'b100000, 6'b100001: ctl_d = {8'b1000_0000, 1'b0, ALU_ADD};
                6'b100010, 6'b100011: ctl_d = {8'b1000_0000, 1'b0, ALU_SUB};
                6'b100100: ctl_d = {8'b1000_0000, 1'b0, ALU_AND};
                6'b100101: ctl_d = {8'b1000_0000, 1'b0, ALU_OR};
                6'b100111: ctl_d = {8'b1000_0000, 1'b0, ALU_NOR};
                6'b101010: ctl_d = EXT_EN ? {8'b1000_0000, 1'b0, ALU_SLT} : ILL;
                default: ctl_d = ILL;
            endcase
            6'b001000: ctl_d = {8'b1000_0011, 1'b0, ALU_ADD};
            6'b001100: ctl_d = {8'b1000_0001, 1'b0, ALU_AND};
            6'b001101: ctl_d = EXT_EN ? {8'b1000_0001, 1'b0, ALU_OR} : ILL;
            6'b001010: ctl_d = EXT_EN ? {8'b1000_0011, 1'b0, ALU_SLT} : ILL;
            6'b100011: ctl_d = {8'b1100_0011, 1'b0, ALU_ADD};
            6'b101011: ctl_d = {8'b0010_0011, 1'b0, ALU_ADD};
            6'b000100: ctl_d = {8'b0000_1010, 1'b0, ALU_SUB};
            6'b000101: ctl_d = EXT_EN ? {8'b0000_1110, 1'b0, ALU_SUB} : ILL;
            6'b000010: ctl_d = {8'b0001_0000, 1'b0, ALU_ADD};
            default:   ctl_d = ILL;
        endcase
    end
    // a pending load blocks any instruction that reads its destination
    assign reads_rt = op == 6'b000000 || op == 6'b101011 || op == 6'b000100 || op == 6'b000101;
    assign hazard   = valid_q && ctl_q[11] && rt_q != 5'd0 &&
                      (in_instr[25:21] == rt_q || (reads_rt && in_instr[20:16] == rt_q));
    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign stall    = hazard && valid_q && out_ready && !flush;
    assign valid_d  = accept || (valid_q && !out_ready && !flush);
    assign cnt_d    = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ctl_q <= ctl_d;
                rs_q  <= in_instr[25:21];
                rt_q  <= in_instr[20:16];
                rd_q  <= op == 6'b000000 ? in_instr[15:11] : in_instr[20:16];
                imm_q <= in_instr[15:0];
            end
        end
    end
    assign {reg_write, mem_read, mem_write, jump, branch, branch_ne, sign_ext, alu_src, illegal, alu_ctr} = ctl_q;
    assign out_valid = valid_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign rd        = rd_q;
    assign imm16     = imm_q;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, directed corner sequences and random traffic against a reference model
module tb_decode_stage;
    typedef struct packed {
        logic v;
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic rw, mr, mw, jp, br, bn, se, asrc, ill;
        logic [3:0] alu;
    } out_t;
    typedef struct {
        logic [31:0] instr;
        logic [7:0]  ctl;
        logic [3:0]  alu;
        logic        ill1;
        logic        ill0;
    } vec_t;

    logic clk = 0;
    always #5 clk = ~clk;
    logic rst = 1, in_valid = 0, flush = 0, out_ready = 1;
    logic [31:0] in_instr = 0;

    logic rdy0, ov0, rw0, mr0, mw0, j0, b0, bn0, se0, as0, ill0;
    logic [4:0] rs0, rt0, rd0;
    logic [15:0] imm0, cnt0;
    logic [3:0] alu0;
    logic rdy1, ov1, rw1, mr1, mw1, j1, b1, bn1, se1, as1, ill1;
    logic [4:0] rs1, rt1, rd1;
    logic [15:0] imm1;
    logic [2:0] cnt1;
    logic [3:0] alu1;
    out_t a0, a1, m0, m1, n0, n1;
    int c0, c1, d0, d1;
    int total = 0, bad = 0;
    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h23, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
    logic [5:0] fns [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a};

    assign a0 = {ov0, rs0, rt0, rd0, imm0, rw0, mr0, mw0, j0, b0, bn0, se0, as0, ill0, alu0};
    assign a1 = {ov1, rs1, rt1, rd1, imm1, rw1, mr1, mw1, j1, b1, bn1, se1, as1, ill1, alu1};

    decode_stage #(.EXT_EN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(rdy0),
        .flush(flush), .out_valid(ov0), .out_ready(out_ready), .rs(rs0), .rt(rt0), .rd(rd0),
        .imm16(imm0), .reg_write(rw0), .mem_read(mr0), .mem_write(mw0), .jump(j0), .branch(b0),
        .branch_ne(bn0), .sign_ext(se0), .alu_src(as0), .alu_ctr(alu0), .illegal(ill0), .stall_cnt(cnt0));
    decode_stage #(.EXT_EN(1'b1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(rdy1),
        .flush(flush), .out_valid(ov1), .out_ready(out_ready), .rs(rs1), .rt(rt1), .rd(rd1),
        .imm16(imm1), .reg_write(rw1), .mem_read(mr1), .mem_write(mw1), .jump(j1), .branch(b1),
        .branch_ne(bn1), .sign_ext(se1), .alu_src(as1), .alu_ctr(alu1), .illegal(ill1), .stall_cnt(cnt1));

    function automatic out_t dec(input logic [31:0] i, input bit ext);
        out_t o;
        bit ok;
        o = '0;
        ok = 1;
        o.v = 1;
        o.rs = i[25:21];
        o.rt = i[20:16];
        o.imm = i[15:0];
        o.rd = (i[31:26] == 6'd0) ? i[15:11] : i[20:16];
        case (i[31:26])
            6'h00: begin
                o.rw = 1;
                case (i[5:0])
                    6'h20, 6'h21: o.alu = 4'h0;
                    6'h22, 6'h23: o.alu = 4'h1;
                    6'h24: o.alu = 4'h9;
                    6'h25: o.alu = 4'hA;
                    6'h27: o.alu = 4'hC;
                    6'h2a: begin o.alu = 4'h7; ok = ext; end
                    default: ok = 0;
                endcase
            end
            6'h08: begin o.rw = 1; o.asrc = 1; o.se = 1; end
            6'h0c: begin o.rw = 1; o.asrc = 1; o.alu = 4'h9; end
            6'h0d: begin o.rw = 1; o.asrc = 1; o.alu = 4'hA; ok = ext; end
            6'h0a: begin o.rw = 1; o.asrc = 1; o.se = 1; o.alu = 4'h7; ok = ext; end
            6'h23: begin o.rw = 1; o.mr = 1; o.asrc = 1; o.se = 1; end
            6'h2b: begin o.mw = 1; o.asrc = 1; o.se = 1; end
            6'h04: begin o.br = 1; o.se = 1; o.alu = 4'h1; end
            6'h05: begin o.br = 1; o.bn = 1; o.se = 1; o.alu = 4'h1; ok = ext; end
            6'h02: o.jp = 1;
            default: ok = 0;
        endcase
        if (!ok) {o.rw, o.mr, o.mw, o.jp, o.br, o.bn, o.se, o.asrc, o.ill, o.alu} = {8'b0, 1'b1, 4'b0};
        return o;
    endfunction

    function automatic bit haz(input out_t m, input logic [31:0] i);
        bit uses_rt;
        uses_rt = i[31:26] inside {6'h00, 6'h2b, 6'h04, 6'h05};
        return m.v && m.mr && m.rt != 0 && (i[25:21] == m.rt || (uses_rt && i[20:16] == m.rt));
    endfunction

    function automatic bit exp_ready(input out_t m);
        return !flush && !haz(m, in_instr) && (!m.v || out_ready);
    endfunction

    task automatic nxt(input out_t m, input int c, input bit ext, input int cmax, output out_t mn, output int cn);
        bit h, r;
        h = haz(m, in_instr);
        r = !flush && !h && (!m.v || out_ready);
        mn = m;
        cn = c;
        if (rst) begin
            mn = '0;
            cn = 0;
        end else begin
            if (in_valid && r) mn = dec(in_instr, ext);
            else if (flush || out_ready) mn.v = 0;
            if (h && out_ready && !flush && cn < cmax) cn++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic f, input logic o, input logic r);
        in_instr = i;
        in_valid = v;
        flush = f;
        out_ready = o;
        rst = r;
    endtask

    task automatic tick();
        #1;
        chk("in_ready0", rdy0, exp_ready(m0));
        chk("in_ready1", rdy1, exp_ready(m1));
        chk("out0", a0, m0);
        chk("out1", a1, m1);
        chk("stall0", cnt0, c0);
        chk("stall1", cnt1, c1);
        nxt(m0, c0, 0, 65535, n0, d0);
        nxt(m1, c1, 1, 7, n1, d1);
        @(posedge clk);
        m0 = n0; m1 = n1; c0 = d0; c1 = d1;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] i);
        bit done;
        done = 0;
        drive(i, 1, 0, 1, 0);
        for (int k = 0; k < 10 && !done; k++) begin
            done = exp_ready(m1);
            tick();
        end
        if (!done) chk("send_timeout", 0, 1);
        drive(0, 0, 0, 1, 0);
    endtask

    function automatic logic [31:0] rnd();
        int k;
        logic [5:0] op, fn;
        k = $urandom_range(0, 12);
        op = (k == 12) ? 6'($urandom) : ops[k];
        k = $urandom_range(0, 8);
        fn = (k == 8) ? 6'($urandom) : fns[k];
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), fn};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [16];
        logic [31:0] b2b [4] = '{32'h20090005, 32'h312A00FF, 32'h8D0B0004, 32'hAD0B0008};
        logic [3:0] b2b_alu [4] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000};
        logic b2b_se [4] = '{1, 0, 1, 1};
        logic b2b_rw [4] = '{1, 1, 1, 0};
        tbl[0]  = '{32'h20090005, 8'b1000_0011, 4'b0000, 0, 0};
        tbl[1]  = '{32'h312A00FF, 8'b1000_0001, 4'b1001, 0, 0};
        tbl[2]  = '{32'h8D0B0004, 8'b1100_0011, 4'b0000, 0, 0};
        tbl[3]  = '{32'hAD0B0008, 8'b0010_0011, 4'b0000, 0, 0};
        tbl[4]  = '{32'h15090003, 8'b0000_1110, 4'b0001, 0, 1};
        tbl[5]  = '{32'h01084820, 8'b1000_0000, 4'b0000, 0, 0};
        tbl[6]  = '{32'h3508000F, 8'b1000_0001, 4'b1010, 0, 1};
        tbl[7]  = '{32'h2908000A, 8'b1000_0011, 4'b0111, 0, 1};
        tbl[8]  = '{32'h0109502A, 8'b1000_0000, 4'b0111, 0, 1};
        tbl[9]  = '{32'h08000010, 8'b0001_0000, 4'b0000, 0, 0};
        tbl[10] = '{32'h11090002, 8'b0000_1010, 4'b0001, 0, 0};
        tbl[11] = '{32'hFC000000, 8'b0000_0000, 4'b0000, 1, 1};
        tbl[12] = '{32'h01095026, 8'b0000_0000, 4'b0000, 1, 1};
        tbl[13] = '{32'h01095027, 8'b1000_0000, 4'b1100, 0, 0};
        tbl[14] = '{32'h01095023, 8'b1000_0000, 4'b0001, 0, 0};
        tbl[15] = '{32'h01095024, 8'b1000_0000, 4'b1001, 0, 0};
        m0 = '0; m1 = '0; c0 = 0; c1 = 0;
        drive(0, 0, 0, 1, 1);
        @(negedge clk);
        tick();
        drive(0, 0, 0, 1, 0);
        #1;
        chk("rst_valid", ov0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_fields", a1, '0);
        tick();

        for (int k = 0; k < 16; k++) begin
            send(tbl[k].instr);
            chk("tbl_valid", ov1, 1);
            chk("tbl_ctl", {rw1, mr1, mw1, j1, b1, bn1, se1, as1}, tbl[k].ctl);
            chk("tbl_alu", alu1, tbl[k].alu);
            chk("tbl_ill_ext", ill1, tbl[k].ill1);
            chk("tbl_ill_base", ill0, tbl[k].ill0);
            tick();
        end
        chk("bne_base_branch", b0, 0);

        for (int k = 0; k < 4; k++) begin
            send(b2b[k]);
            chk("b2b_alu", alu0, b2b_alu[k]);
            chk("b2b_se", se0, b2b_se[k]);
            chk("b2b_rw", rw0, b2b_rw[k]);
        end
        tick();

        drive(0, 0, 0, 1, 1);
        tick();
        drive(32'h8C080000, 1, 0, 1, 0);
        tick();
        drive(32'h01084820, 1, 0, 1, 0);
        #1;
        chk("lu_ready_low", rdy0, 0);
        tick();
        #1;
        chk("lu_gap", ov0, 0);
        chk("lu_ready_high", rdy0, 1);
        tick();
        drive(0, 0, 0, 1, 0);
        chk("lu_valid", ov0, 1);
        chk("lu_rd", rd0, 9);
        chk("lu_stall", cnt0, 1);

        drive(32'h20090005, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", rdy0, 0);
            chk("hold_rd", rd0, 9);
            chk("hold_valid", ov0, 1);
            tick();
        end
        drive(32'h20090005, 1, 0, 1, 0);
        #1;
        chk("release_ready", rdy0, 1);
        tick();
        chk("release_imm", imm0, 16'h0005);
        chk("release_valid", ov0, 1);

        drive(32'h312A00FF, 1, 1, 1, 0);
        #1;
        chk("flush_ready", rdy0, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        chk("flush_valid", ov0, 0);
        tick();
        chk("flush_noaccept", ov0, 0);

        send(32'h20090005);
        drive(32'h312A00FF, 1, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("midrst_out0", a0, '0);
        chk("midrst_out1", a1, '0);
        chk("midrst_stall", cnt0, 0);
        tick();

        for (int k = 0; k < 9; k++) begin
            send(32'h8C080000);
            send(32'h01084820);
        end
        tick();
        chk("sat_stall_ext", cnt1, 7);
        chk("sat_stall_base", cnt0, 9);

        for (int k = 0; k < 600; k++) begin
            drive(rnd(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
